// File: rtl/dmem_axi_bridge.sv
// dmem_axi_bridge
// Bridges a single-request data-cache port onto a single-beat AXI master.
// One request is in flight at a time. The request is latched in IDLE, so the
// cache may change its inputs freely until c_ready pulses.
//
// Ports
//   clk, clrn                   clock, asynchronous active-low reset
//   c_a, c_din, c_wen, c_size,
//   c_rw, c_strobe              cache request (level strobe, held until c_ready)
//   c_dout, c_ready             cache read data and one-cycle completion pulse
//   araddr/arsize/arvalid/arready, rdata/rvalid/rready      AXI read channels
//   awaddr/awsize/awvalid/awready, wdata/wstrb/wvalid/wready,
//   bvalid/bready                                            AXI write channels
//
// Build option
//   DBRIDGE_KSEG_MAP_EN  when defined, kseg0/kseg1 addresses (bits[31:29] of
//                        3'b100 or 3'b101) are issued with bits[31:29] cleared.
//                        This assumes A_WIDTH >= 32.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for c_strobe; latches the request when it is seen
// AR    | arvalid high until arready
// R     | rready high until rvalid; read data captured into c_dout
// AWW   | awvalid/wvalid high, each dropping after its own handshake
// B     | bready high until bvalid (bresp ignored)
// DONE  | c_ready high for one cycle, then back to IDLE
module dmem_axi_bridge #(
    parameter int A_WIDTH = 32
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic [A_WIDTH-1:0] c_a,
    input  logic [31:0]        c_din,
    output logic [31:0]        c_dout,
    input  logic               c_strobe,
    input  logic [3:0]         c_wen,
    input  logic [1:0]         c_size,
    input  logic               c_rw,
    output logic               c_ready,
    output logic [A_WIDTH-1:0] araddr,
    output logic [2:0]         arsize,
    output logic               arvalid,
    input  logic               arready,
    input  logic [31:0]        rdata,
    input  logic               rvalid,
    output logic               rready,
    output logic [A_WIDTH-1:0] awaddr,
    output logic [2:0]         awsize,
    output logic               awvalid,
    input  logic               awready,
    output logic [31:0]        wdata,
    output logic [3:0]         wstrb,
    output logic               wvalid,
    input  logic               wready,
    input  logic               bvalid,
    output logic               bready
);

    typedef enum logic [2:0] {
        IDLE,
        AR,
        R,
        AWW,
        B,
        DONE
    } state_t;

    state_t state;

    // A write channel counts as finished once its valid has dropped, or in the
    // cycle its handshake happens.
    logic aw_ok;
    logic w_ok;

    assign aw_ok = !awvalid || awready;
    assign w_ok  = !wvalid  || wready;

    function automatic logic [A_WIDTH-1:0] map_addr(input logic [A_WIDTH-1:0] a);
        logic [A_WIDTH-1:0] m;
        m = a;
`ifdef DBRIDGE_KSEG_MAP_EN
        if (a[31:30] == 2'b10) begin
            m[31:29] = 3'b000;
        end
`endif
        return m;
    endfunction

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state   <= IDLE;
            c_ready <= 1'b0;
            c_dout  <= '0;
            araddr  <= '0;
            awaddr  <= '0;
            arsize  <= '0;
            awsize  <= '0;
            arvalid <= 1'b0;
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            rready  <= 1'b0;
            bready  <= 1'b0;
            wdata   <= '0;
            wstrb   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    c_ready <= 1'b0;
                    if (c_strobe) begin
                        araddr <= map_addr(c_a);
                        awaddr <= map_addr(c_a);
                        arsize <= {1'b0, c_size};
                        awsize <= {1'b0, c_size};
                        wdata  <= c_din;
                        wstrb  <= c_wen;
                        if (c_rw) begin
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            state   <= AWW;
                        end else begin
                            arvalid <= 1'b1;
                            state   <= AR;
                        end
                    end
                end
                AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= R;
                    end
                end
                R: begin
                    if (rvalid) begin
                        c_dout  <= rdata;
                        rready  <= 1'b0;
                        c_ready <= 1'b1;
                        state   <= DONE;
                    end
                end
                AWW: begin
                    if (awvalid && awready) begin
                        awvalid <= 1'b0;
                    end
                    if (wvalid && wready) begin
                        wvalid <= 1'b0;
                    end
                    if (aw_ok && w_ok) begin
                        bready <= 1'b1;
                        state  <= B;
                    end
                end
                B: begin
                    if (bvalid) begin
                        bready  <= 1'b0;
                        c_ready <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    c_ready <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_axi_bridge.sv
// Directed bench for dmem_axi_bridge. Inputs are driven 1 ns after the rising
// edge and outputs are sampled at the same point, so each step() moves one
// cycle forward and shows the registers produced by that edge.
module tb_dmem_axi_bridge;

    logic        clk;
    logic        clrn;
    logic [31:0] c_a;
    logic [31:0] c_din;
    logic [31:0] c_dout;
    logic        c_strobe;
    logic [3:0]  c_wen;
    logic [1:0]  c_size;
    logic        c_rw;
    logic        c_ready;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic        bvalid;
    logic        bready;

    int n_checks = 0;
    int n_errors = 0;

    dmem_axi_bridge #(.A_WIDTH(32)) dut (
        .clk(clk), .clrn(clrn),
        .c_a(c_a), .c_din(c_din), .c_dout(c_dout), .c_strobe(c_strobe),
        .c_wen(c_wen), .c_size(c_size), .c_rw(c_rw), .c_ready(c_ready),
        .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic rw, input logic [31:0] a, input logic [1:0] sz,
                       input logic [3:0] wen, input logic [31:0] din);
        c_strobe = 1'b1;
        c_rw     = rw;
        c_a      = a;
        c_size   = sz;
        c_wen    = wen;
        c_din    = din;
    endtask

    logic [31:0] kseg_exp;

    initial begin
        c_a = '0; c_din = '0; c_strobe = 0; c_wen = '0; c_size = '0; c_rw = 0;
        arready = 0; rdata = '0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        clrn = 1'b0;
        #3;
        chk("rst_c_ready", {31'd0, c_ready}, 32'd0);
        chk("rst_valids", {27'd0, arvalid, awvalid, wvalid, rready, bready}, 32'd0);
        chk("rst_c_dout", c_dout, 32'd0);
        chk("rst_araddr", araddr, 32'd0);
        chk("rst_sizes", {26'd0, arsize, awsize}, 32'd0);
        step();
        step();
        clrn = 1'b1;
        step();

        // Zero-wait word read: c_ready expected in cycle 3.
        req(1'b0, 32'h1FAF_0010, 2'd2, 4'h0, 32'h0);
        arready = 1; rvalid = 1; rdata = 32'hDEAD_BEEF;
        step();  // cycle 1
        chk("rd_arvalid_c1", {31'd0, arvalid}, 32'd1);
        chk("rd_araddr", araddr, 32'h1FAF_0010);
        chk("rd_arsize", {29'd0, arsize}, 32'd2);
        c_a = 32'h0000_0BAD; c_size = 2'd0;   // must be ignored
        step();  // cycle 2
        chk("rd_r_state", {30'd0, arvalid, rready}, 32'b01);
        chk("rd_ready_early", {31'd0, c_ready}, 32'd0);
        chk("rd_araddr_held", araddr, 32'h1FAF_0010);
        step();  // cycle 3
        chk("rd_c_ready_c3", {31'd0, c_ready}, 32'd1);
        chk("rd_c_dout", c_dout, 32'hDEAD_BEEF);
        c_strobe = 0; rvalid = 0; arready = 0;
        step();
        chk("rd_c_ready_pulse", {31'd0, c_ready}, 32'd0);

        // Byte write, wready immediate, awready two cycles later.
        req(1'b1, 32'h1FAF_F000, 2'd0, 4'b0010, 32'h0000_AB00);
        wready = 1; awready = 0;
        step();  // cycle 1: both valids up, W handshakes at the end
        chk("wr_valids_c1", {30'd0, awvalid, wvalid}, 32'b11);
        chk("wr_wstrb", {28'd0, wstrb}, 32'b0010);
        chk("wr_wdata", wdata, 32'h0000_AB00);
        chk("wr_awaddr", awaddr, 32'h1FAF_F000);
        chk("wr_awsize", {29'd0, awsize}, 32'd0);
        step();  // cycle 2
        chk("wr_valids_c2", {30'd0, awvalid, wvalid}, 32'b10);
        chk("wr_bready_c2", {31'd0, bready}, 32'd0);
        step();  // cycle 3
        awready = 1;
        chk("wr_valids_c3", {30'd0, awvalid, wvalid}, 32'b10);
        step();  // cycle 4: in B
        chk("wr_b_state", {29'd0, awvalid, wvalid, bready}, 32'b001);
        chk("wr_no_ready_yet", {31'd0, c_ready}, 32'd0);
        bvalid = 1;
        step();  // cycle 5
        chk("wr_c_ready", {31'd0, c_ready}, 32'd1);
        chk("wr_bready_drop", {31'd0, bready}, 32'd0);
        chk("wr_dout_kept", c_dout, 32'hDEAD_BEEF);
        c_strobe = 0; bvalid = 0; awready = 0; wready = 0;
        step();
        chk("wr_c_ready_pulse", {31'd0, c_ready}, 32'd0);

        // Write-back then refill, strobe held; AW before W this time.
        req(1'b1, 32'h0000_0100, 2'd2, 4'hF, 32'h1122_3344);
        awready = 1; wready = 0; bvalid = 1; arready = 1; rvalid = 1;
        rdata = 32'hCAFE_F00D;
        step();  // cycle 1
        chk("wb_valids_c1", {30'd0, awvalid, wvalid}, 32'b11);
        step();  // cycle 2
        chk("wb_valids_c2", {30'd0, awvalid, wvalid}, 32'b01);
        wready = 1;
        step();  // cycle 3
        chk("wb_b_state", {29'd0, awvalid, wvalid, bready}, 32'b001);
        step();  // cycle 4
        chk("wb_c_ready", {31'd0, c_ready}, 32'd1);
        c_rw = 0; c_a = 32'h0000_0200;
        step();  // cycle 5: back in IDLE, read not yet issued
        chk("wb_gap_ready", {31'd0, c_ready}, 32'd0);
        chk("wb_gap_arvalid", {31'd0, arvalid}, 32'd0);
        step();  // cycle 6
        chk("rf_arvalid", {31'd0, arvalid}, 32'd1);
        chk("rf_araddr", araddr, 32'h0000_0200);
        step();  // cycle 7
        chk("rf_rready", {31'd0, rready}, 32'd1);
        step();  // cycle 8
        chk("rf_c_ready", {31'd0, c_ready}, 32'd1);
        chk("rf_c_dout", c_dout, 32'hCAFE_F00D);
        c_strobe = 0; awready = 0; wready = 0; bvalid = 0; rvalid = 0; arready = 0;
        step();
        chk("rf_c_ready_pulse", {31'd0, c_ready}, 32'd0);

        // Reset while waiting in R.
        req(1'b0, 32'h0000_0300, 2'd2, 4'h0, 32'h0);
        arready = 1;
        step();
        step();
        chk("rst_mid_in_r", {31'd0, rready}, 32'd1);
        rvalid = 1; rdata = 32'h0000_0055;
        #2;
        clrn = 1'b0;
        #1;
        chk("rst_mid_valids", {27'd0, arvalid, awvalid, wvalid, rready, bready}, 32'd0);
        chk("rst_mid_c_ready", {31'd0, c_ready}, 32'd0);
        chk("rst_mid_c_dout", c_dout, 32'd0);
        c_strobe = 0; rvalid = 0;
        step();
        step();
        chk("rst_hold_c_ready", {31'd0, c_ready}, 32'd0);
        clrn = 1'b1;
        step();
        chk("post_rst_idle", {31'd0, c_ready}, 32'd0);
        req(1'b0, 32'h0000_0400, 2'd1, 4'h0, 32'h0);
        rvalid = 1; rdata = 32'h600D_CAFE;
        step();
        chk("post_rst_arvalid", {31'd0, arvalid}, 32'd1);
        chk("post_rst_arsize", {29'd0, arsize}, 32'd1);
        step();
        step();
        chk("post_rst_c_ready", {31'd0, c_ready}, 32'd1);
        chk("post_rst_c_dout", c_dout, 32'h600D_CAFE);
        c_strobe = 0;
        step();

        // kseg1 boot address.
`ifdef DBRIDGE_KSEG_MAP_EN
        kseg_exp = 32'h1FC0_0000;
`else
        kseg_exp = 32'hBFC0_0000;
`endif
        req(1'b0, 32'hBFC0_0000, 2'd2, 4'h0, 32'h0);
        rdata = 32'h1234_5678;
        step();
        chk("kseg_araddr", araddr, kseg_exp);
        step();
        step();
        chk("kseg_c_ready", {31'd0, c_ready}, 32'd1);
        c_strobe = 0; rvalid = 0; arready = 0;
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
